// File: rtl/cnn_acc_pkg.sv
// ============================================================================
// Module      : cnn_acc_pkg
// Description : Shared widths, FSM state type and clog2 helper for the CNN
//               convolution accumulate / requantize stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cnn_acc_pkg;

    localparam int C_PROD_WIDTH = 22;
    localparam int C_ACC_WIDTH  = 32;
    localparam int C_N_TERMS    = 9;
    localparam int C_BIAS_WIDTH = 16;
    localparam int C_FRAC_SHIFT = 8;
    localparam int C_OUT_WIDTH  = 13;

    typedef enum logic [0:0] {
        S_ACC = 1'b0,
        S_OUT = 1'b1
    } acc_state_e;

    // Returns 0 for n <= 1; callers clamp the counter width to at least 1.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cnn_acc_requant.sv
// ============================================================================
// Module      : cnn_acc_requant
// Description : Round-half-up, arithmetic right shift, ReLU and unsigned
//               saturation from accumulator format to activation format.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cnn_acc_requant #(
    parameter int ACC_WIDTH  = 32,
    parameter int FRAC_SHIFT = 8,
    parameter int OUT_WIDTH  = 13
) (
    input  logic signed [ACC_WIDTH-1:0] i_sum,
    output logic        [OUT_WIDTH-1:0] o_act
);

    localparam logic signed [ACC_WIDTH-1:0] C_HALF = ACC_WIDTH'(64'd1 << (FRAC_SHIFT - 1));

    logic signed [ACC_WIDTH-1:0] w_rnd;
    logic signed [ACC_WIDTH-1:0] w_shr;
    logic                        w_neg;
    logic                        w_ovf;

    assign w_rnd = i_sum + C_HALF;
    assign w_shr = w_rnd >>> FRAC_SHIFT;
    assign w_neg = w_shr[ACC_WIDTH-1];
    // Any set bit between the sign and the activation MSB means r exceeds the range.
    assign w_ovf = |w_shr[ACC_WIDTH-2:OUT_WIDTH];

    always_comb begin
        o_act = w_shr[OUT_WIDTH-1:0];
        if (w_neg) begin
            o_act = '0;
        end else if (w_ovf) begin
            o_act = '1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/cnn_conv_acc_relu.sv
// ============================================================================
// Module      : cnn_conv_acc_relu
// Description : Accumulates N_TERMS signed products plus bias per output pixel,
//               then requantizes with ReLU/saturation to an unsigned activation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cnn_conv_acc_relu
    import cnn_acc_pkg::*;
#(
    parameter int PROD_WIDTH = C_PROD_WIDTH,
    parameter int ACC_WIDTH  = C_ACC_WIDTH,
    parameter int N_TERMS    = C_N_TERMS,
    parameter int BIAS_WIDTH = C_BIAS_WIDTH,
    parameter int FRAC_SHIFT = C_FRAC_SHIFT,
    parameter int OUT_WIDTH  = C_OUT_WIDTH
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic [PROD_WIDTH-1:0] prod_din,
    input  logic                  prod_valid,
    output logic                  prod_ready,
    input  logic [BIAS_WIDTH-1:0] bias,
    output logic [OUT_WIDTH-1:0]  dout,
    output logic                  dout_valid,
    input  logic                  dout_ready
);

    localparam int              CNT_W  = (N_TERMS > 1) ? clog2(N_TERMS) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(N_TERMS - 1);

    acc_state_e                  r_state;
    logic [CNT_W-1:0]            r_cnt;
    logic signed [ACC_WIDTH-1:0] r_acc;
    logic [OUT_WIDTH-1:0]        r_dout;
    logic                        r_dout_valid;

    logic signed [ACC_WIDTH-1:0] w_prod_ext;
    logic signed [ACC_WIDTH-1:0] w_bias_ext;
    logic signed [ACC_WIDTH-1:0] w_base;
    logic signed [ACC_WIDTH-1:0] w_sum;
    logic                        w_first;
    logic                        w_last;
    logic                        w_accept;
    logic [OUT_WIDTH-1:0]        w_req;

    assign w_prod_ext = {{(ACC_WIDTH - PROD_WIDTH){prod_din[PROD_WIDTH-1]}}, prod_din};
    assign w_bias_ext = {{(ACC_WIDTH - BIAS_WIDTH){bias[BIAS_WIDTH-1]}}, bias};

    // The first term of a window restarts from the bias, discarding the old sum.
    assign w_first = (r_cnt == '0);
    assign w_last  = (r_cnt == C_LAST);
    assign w_base  = w_first ? w_bias_ext : r_acc;
    assign w_sum   = w_base + w_prod_ext;

    assign prod_ready = (r_state == S_ACC) | dout_ready;
    assign w_accept   = prod_valid & prod_ready;

    cnn_acc_requant #(
        .ACC_WIDTH  (ACC_WIDTH),
        .FRAC_SHIFT (FRAC_SHIFT),
        .OUT_WIDTH  (OUT_WIDTH)
    ) u_requant (
        .i_sum (w_sum),
        .o_act (w_req)
    );

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_state      <= S_ACC;
            r_cnt        <= '0;
            r_acc        <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
        end else begin
            if (r_state == S_OUT && dout_ready) begin
                r_state      <= S_ACC;
                r_dout_valid <= 1'b0;
            end
            // A completing window overrides the release above (N_TERMS = 1 case).
            if (w_accept) begin
                r_acc <= w_sum;
                if (w_last) begin
                    r_cnt        <= '0;
                    r_dout       <= w_req;
                    r_dout_valid <= 1'b1;
                    r_state      <= S_OUT;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;

endmodule

`default_nettype wire

// File: doc/cnn_conv_acc_relu.md
# cnn_conv_acc_relu

Downstream stage of the 13-bit-unsigned × 9-bit-signed conv multiplier in the fixed-point CNN datapath. It consumes the 22-bit signed products one per cycle and accumulates a fixed number of them per output pixel (one kernel window). It adds a per-channel bias, rounds and shifts back to the activation format, then applies ReLU and saturation. The resulting 13-bit unsigned activation is in the same format as the multiplier's `din0`, so it can feed the next layer directly.

## Interface
- `PROD_WIDTH`, default 22: product width, signed.
- `ACC_WIDTH`, default 32: accumulator width, signed. Must satisfy ≥ PROD_WIDTH + clog2(N_TERMS) + 1.
- `N_TERMS`, default 9: products per output (3×3 kernel). Must be ≥ 1.
- `BIAS_WIDTH`, default 16: bias width, signed, in the product's fractional format.
- `FRAC_SHIFT`, default 8: right shift from product format to activation format. Must be ≥ 1.
- `OUT_WIDTH`, default 13: activation width, unsigned.
- `ap_clk`, in, 1: sole clock. All logic is on the rising edge.
- `ap_rst`, in, 1: synchronous, active-high reset.
- `prod_din`, in, PROD_WIDTH: signed product from the multiplier.
- `prod_valid`, in, 1: `prod_din` is valid.
- `prod_ready`, out, 1: the block accepts `prod_din` this cycle.
- `bias`, in, BIAS_WIDTH: signed bias. Sampled with the first product of each window.
- `dout`, out, OUT_WIDTH: activation result.
- `dout_valid`, out, 1: `dout` is valid.
- `dout_ready`, in, 1: downstream accepts `dout`.

## Operation
- **Handshake.** A transfer occurs when `valid && ready` in the same cycle, on both ports. Producers must not change a presented item until it is accepted.
- **FSM: S_ACC.** Accepts products. `prod_ready` = 1.
- **FSM: S_OUT.** Holds the result with `dout_valid` = 1. `prod_ready` = `dout_ready`: a new window may begin in the same cycle the result is taken.
- **Term counter `cnt`.** Range 0..N_TERMS-1. Increments on each accepted product and wraps to 0 after N_TERMS-1.
- **First product (`cnt` = 0).** acc ← sext(bias) + sext(prod_din). The previous accumulator value is ignored.
- **Middle products (0 < `cnt` < N_TERMS-1).** acc ← acc + sext(prod_din).
- **Last product (`cnt` = N_TERMS-1).**
  - sum = acc + sext(prod_din). If N_TERMS = 1, sum = sext(bias) + sext(prod_din).
  - Requantize: r = (sum + 2^(FRAC_SHIFT-1)) >>> FRAC_SHIFT. This is round-half-up, using an arithmetic shift at full ACC_WIDTH.
  - ReLU/saturate: if r < 0, `dout` ← 0. If r > 2^OUT_WIDTH − 1, `dout` ← 2^OUT_WIDTH − 1. Otherwise `dout` ← r[OUT_WIDTH-1:0].
  - The FSM goes to S_OUT.
- **Leaving S_OUT.** If `dout_ready`, `dout_valid` drops next cycle unless that same cycle's accepted product completes a window. That can only happen when N_TERMS = 1, in which case `dout_valid` stays 1 with the new value.
- **Reset.** Synchronous and takes priority over all other activity.
  - Outputs: `dout` = 0, `dout_valid` = 0, `prod_ready` = 1 (from the cycle after `ap_rst` deasserts).
  - Internal: state = S_ACC, `cnt` = 0, acc = 0.
  - A partially accumulated window is discarded. A held result is discarded.
- **Ignored inputs.** `prod_din` and `bias` are ignored when no transfer occurs. `bias` is ignored except when `cnt` = 0.
- **No overflow.** The accumulator cannot overflow under the width rule. There is no error output.

## Timing
- **Latency.** The product accepted at cycle t with `cnt` = N_TERMS-1 produces `dout_valid` = 1 at t+1.
- **Throughput.** One output every N_TERMS cycles with continuous `prod_valid` and `dout_ready` held at 1. There are no bubbles.
- **Backpressure.** While `dout_valid` = 1 and `dout_ready` = 0, `dout` is stable and `prod_ready` = 0.
- **Registered outputs.** `dout` and `dout_valid` are registered. `prod_ready` is combinational from state and `dout_ready` only; there is no path from `prod_valid`.
- **Critical path.** acc add → rounding add → compare/saturate into the `dout` register. This is a single cycle, with no internal pipeline.

## Structure
- **Package `cnn_acc_pkg`.**
  - Default width constants.
  - State enum {S_ACC, S_OUT}.
  - A function `clog2`, used for the `cnt` width.
- **Sub-module `cnn_acc_requant`.** Combinational rounding, arithmetic shift, ReLU and saturation, taking ACC_WIDTH in and giving OUT_WIDTH out. It is instantiated once and is reusable for pooling-stage requant.

## Test plan
- **Basic window.** 9 products of 256 with bias 0 → sum 2304, r = (2304+128)>>8 = 9. Expect `dout` = 9 one cycle after the 9th accept.
- **Rounding.** All products 0. Bias 384 → `dout` = 2. Bias 383 → `dout` = 1. Bias −129 → `dout` = 0, via r = −1 and ReLU.
- **Saturation.** 9 products of 2097151 with bias 0 → r = 73728 → `dout` = 8191. Also: 9 products of −1000 → `dout` = 0.
- **Backpressure.** Hold `dout_ready` = 0 for 5 cycles after a result. Expect `dout` stable, `prod_ready` = 0 and no products lost. Then raise `dout_ready` with `prod_valid` = 1 and expect the next window's first product accepted in that same cycle.
- **Streaming.** 4 back-to-back windows with random products and biases, `prod_valid` and `dout_ready` held at 1. Expect one `dout_valid` pulse every 9 cycles, matching the reference model.
- **Reset mid-window.** Assert `ap_rst` after 4 accepted products. Then feed 9 products of 256 with bias 0 → `dout` = 9, with no residue from the aborted window.
